high_bit: RTL and testbench
===========================

Name: high_bit

Overview:
- Registered highest-set-bit (leading-one) index encoder.
- Takes an IN_WIDTH-bit vector and returns the index of its most significant set bit.
- An all-zero input returns a reserved all-ones code.
- Used by FP normalisation logic to find the leading one of a mantissa/sum for shift-amount calculation.

Parameters:
- OUT_WIDTH, 4, width of index output; index range uses OUT_WIDTH-1 bits, extra bit allows the distinct "no bit set" code.
- IN_WIDTH, 1<<(OUT_WIDTH-1) (=8), input vector width; must be at most 2**(OUT_WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies `in` this cycle.
- in  input  IN_WIDTH  vector to encode.
- out_valid  output  1  registered in_valid; high the cycle after an accepted input.
- out  output  OUT_WIDTH  index of highest set bit of the accepted input; all ones when input was zero.
- zero  output  1  high when the accepted input was all zeros.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: out = all ones ({OUT_WIDTH{1'b1}}), zero = 1, out_valid = 0.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1:
  - out <= index of the highest i where in[i]=1, zero-extended to OUT_WIDTH.
  - zero <= 0.
  - If in == 0: out <= all ones (15 for OUT_WIDTH=4), zero <= 1.
- With in_valid=0: out and zero hold their previous values; out_valid <= 0.
- out_valid <= in_valid every cycle. There is no back-pressure; a new input is accepted every cycle.
- Priority is strictly MSB-first. Lower set bits are ignored (8'b0101_0011 gives 6).
- Since IN_WIDTH <= 2**(OUT_WIDTH-1), a valid index never equals the all-ones code.
- rst has priority over in_valid in the same cycle. Reset mid-stream discards the in-flight result.
- Encoding logic is combinational: a log2(IN_WIDTH)-level binary tree of 2:1 leading-one merge nodes.
  - Each node outputs {any_set, index}.
  - The upper half wins when its any_set is high.
  - No linear ripple chain.
- X on `in` while in_valid=0 must not affect outputs.

Optional Feature:
- Macro HIGH_BIT_MASK_EN.
- When defined: adds output port out_mask (IN_WIDTH) = registered one-hot mask of the highest set bit.
  - Same latency and hold rules as out.
  - Reset value 0; all zeros when the input was zero.
- When undefined: port and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package high_bit_pkg:
  - Default localparams HB_OUT_WIDTH=4 and HB_IN_WIDTH=8.
  - Function hb_none_code(width) returning the all-ones code.
  - Typedef hb_node_t {logic any; logic [OUT_WIDTH-2:0] idx} for tree nodes.
- One natural sub-module, high_bit_node: the 2:1 merge cell.
  - Instantiated in a generate tree inside high_bit.
  - Combinational only.

Test Plan:
- Reset: assert rst 2 cycles -> out=4'hF, zero=1, out_valid=0; then in_valid=1, in=8'b0100_0000 with rst=1 -> outputs stay at reset values.
- in=8'b0100_0000, in_valid=1 -> next cycle out=6, zero=0, out_valid=1; in=8'b0001_0000 -> out=4.
- in=8'b0000_0000 -> out=15, zero=1, out_valid=1.
- Extremes: in=8'b1111_1111 -> 7; in=8'b0000_0001 -> 0; in=8'b1000_0000 -> 7; in=8'b0101_0011 -> 6.
- Hold: in=8'b0000_1000 accepted (out=3), then in_valid=0 with in=8'hFF for 3 cycles -> out stays 3, out_valid=0.
- Back-to-back random stream of 1000 values with in_valid toggling -> out/zero/out_valid match a reference model delayed 1 cycle; with HIGH_BIT_MASK_EN, out_mask == 1<<out (0 when zero=1).

Source files
------------

// File: rtl/high_bit_pkg.sv
// Shared definitions for the high_bit leading-one encoder.
//   HB_OUT_WIDTH / HB_IN_WIDTH : default output / input widths
//   hb_none_code(width)        : all-ones "no bit set" code of the given width
//   hb_node_t                  : {any, idx} tree node sized for the default widths
package high_bit_pkg;

  localparam int unsigned HB_OUT_WIDTH = 4;
  localparam int unsigned HB_IN_WIDTH  = 8;

  // Returned in the low `width` bits; callers truncate to their own width.
  function automatic logic [63:0] hb_none_code(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

  typedef struct packed {
    logic                    any;
    logic [HB_OUT_WIDTH-2:0] idx;
  } hb_node_t;

endpackage

// File: rtl/high_bit_node.sv
// 2:1 leading-one merge cell for the high_bit encoder tree (combinational).
//   hi_i   : node covering the upper half of the span
//   lo_i   : node covering the lower half of the span
//   node_o : merged node; the upper half wins whenever it has any bit set
// node_t must be a packed struct with fields `any` and `idx`; indices are
// absolute bit positions, so no offset is added when the upper half wins.
module high_bit_node
  import high_bit_pkg::*;
#(
  parameter type node_t = hb_node_t
) (
  input  node_t hi_i,
  input  node_t lo_i,
  output node_t node_o
);

  always_comb begin
    node_o     = lo_i;
    node_o.any = hi_i.any | lo_i.any;
    if (hi_i.any) begin
      node_o.idx = hi_i.idx;
    end
  end

endmodule

// File: rtl/high_bit.sv
// Registered highest-set-bit (leading-one) index encoder, 1-cycle latency.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : qualifies `in`
//   in        : vector to encode
//   out_valid : in_valid delayed by one cycle
//   out       : index of the highest set bit, all ones when the input was zero
//   zero      : the accepted input was all zeros
//   out_mask  : one-hot mask of the highest set bit (only with HIGH_BIT_MASK_EN)
// IN_WIDTH must not exceed 2**(OUT_WIDTH-1) so a real index never collides with
// the all-ones "no bit set" code.
module high_bit
  import high_bit_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = HB_OUT_WIDTH,
  parameter int unsigned IN_WIDTH  = 1 << (OUT_WIDTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out,
`ifdef HIGH_BIT_MASK_EN
  output logic [IN_WIDTH-1:0]  out_mask,
`endif
  output logic                 zero
);

  localparam int unsigned IdxW      = OUT_WIDTH - 1;
  localparam int unsigned Levels    = $clog2(IN_WIDTH);
  localparam int unsigned NumLeaves = 1 << Levels;

  localparam logic [OUT_WIDTH-1:0] NoneCode = OUT_WIDTH'(hb_none_code(OUT_WIDTH));

  typedef struct packed {
    logic            any;
    logic [IdxW-1:0] idx;
  } node_t;

  // Binary merge tree: level 0 holds the leaves (padded to a power of two with
  // empty leaves), level Levels holds the single root.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    node_t nodes [1 << (Levels - l)];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < NumLeaves; j++) begin : g_bit
        if (j < IN_WIDTH) begin : g_real
          assign nodes[j] = '{any: in[j], idx: IdxW'(j)};
        end else begin : g_pad
          assign nodes[j] = '{any: 1'b0, idx: IdxW'(j)};
        end
      end
    end else begin : g_merge
      for (genvar j = 0; j < (1 << (Levels - l)); j++) begin : g_cell
        high_bit_node #(
          .node_t(node_t)
        ) u_node (
          .hi_i  (g_lvl[l-1].nodes[2*j+1]),
          .lo_i  (g_lvl[l-1].nodes[2*j]),
          .node_o(nodes[j])
        );
      end
    end
  end

  node_t root;
  assign root = g_lvl[Levels].nodes[0];

  logic [OUT_WIDTH-1:0] out_d, out_q;
  logic                 zero_d, zero_q;
  logic                 valid_d, valid_q;

  // `in` is only looked at when in_valid is high, so X on an idle input
  // cannot reach the held outputs.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    valid_d = in_valid;
    if (in_valid) begin
      zero_d = ~root.any;
      out_d  = root.any ? OUT_WIDTH'(root.idx) : NoneCode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= NoneCode;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

`ifdef HIGH_BIT_MASK_EN
  localparam logic [IN_WIDTH-1:0] MaskOne = IN_WIDTH'(1);

  logic [IN_WIDTH-1:0] mask_d, mask_q;

  always_comb begin
    mask_d = mask_q;
    if (in_valid) begin
      mask_d = root.any ? (MaskOne << root.idx) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign out_mask = mask_q;
`endif

endmodule

// File: tb/tb_high_bit.sv
// Self-checking bench for high_bit (OUT_WIDTH=4, IN_WIDTH=8). Each driven cycle
// pushes the model's expected registered outputs; they are popped and compared
// one cycle later. Define HIGH_BIT_MASK_EN for both files to cover out_mask.
module tb_high_bit;

  localparam int unsigned OW = 4;
  localparam int unsigned IW = 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in;
  logic          out_valid;
  logic [OW-1:0] out;
  logic          zero;
`ifdef HIGH_BIT_MASK_EN
  logic [IW-1:0] out_mask;
`endif

  high_bit #(
    .OUT_WIDTH(OW),
    .IN_WIDTH (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in),
    .out_valid(out_valid),
    .out      (out),
`ifdef HIGH_BIT_MASK_EN
    .out_mask (out_mask),
`endif
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [OW-1:0] out;
    logic          zero;
    logic [IW-1:0] mask;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference state: what the registered outputs should hold.
  logic [OW-1:0] m_out;
  logic          m_zero;
  logic [IW-1:0] m_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic drive(input logic r, input logic v, input logic [IW-1:0] d, input string tag);
    exp_t e;
    exp_t got;
    rst      = r;
    in_valid = v;
    in       = d;
    if (r) begin
      m_out  = 4'hF;
      m_zero = 1'b1;
      m_mask = '0;
    end else if (v) begin
      m_out  = 4'hF;
      m_zero = 1'b1;
      m_mask = '0;
      for (int i = 0; i < IW; i++) begin
        if (d[i]) begin
          m_out  = OW'(i);
          m_zero = 1'b0;
          m_mask = IW'(1) << i;
        end
      end
    end
    e.valid = v & ~r;
    e.out   = m_out;
    e.zero  = m_zero;
    e.mask  = m_mask;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq({tag, ".out"}, 32'(out), 32'(got.out));
    check_eq({tag, ".zero"}, 32'(zero), 32'(got.zero));
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(got.valid));
`ifdef HIGH_BIT_MASK_EN
    check_eq({tag, ".mask"}, 32'(out_mask), 32'(got.mask));
`endif
  endtask

  initial begin
    logic          v;
    logic          r;
    logic [IW-1:0] d;

    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in       = '0;
    m_out    = 4'hF;
    m_zero   = 1'b1;
    m_mask   = '0;

    // Reset, including a valid input that reset must override.
    drive(1'b1, 1'b0, 8'h00, "rst0");
    drive(1'b1, 1'b0, 8'h00, "rst1");
    drive(1'b1, 1'b1, 8'b0100_0000, "rst_pri");

    // Directed patterns and extremes.
    drive(1'b0, 1'b1, 8'b0100_0000, "b6");
    drive(1'b0, 1'b1, 8'b0001_0000, "b4");
    drive(1'b0, 1'b1, 8'b0000_0000, "zero");
    drive(1'b0, 1'b1, 8'b1111_1111, "all1");
    drive(1'b0, 1'b1, 8'b0000_0001, "lsb");
    drive(1'b0, 1'b1, 8'b1000_0000, "msb");
    drive(1'b0, 1'b1, 8'b0101_0011, "prio");

    // Hold while idle, with a busy and an unknown input on the bus.
    drive(1'b0, 1'b1, 8'b0000_1000, "b3");
    drive(1'b0, 1'b0, 8'hFF, "hold0");
    drive(1'b0, 1'b0, 8'hFF, "hold1");
    drive(1'b0, 1'b0, 8'hFF, "hold2");
    drive(1'b0, 1'b0, 8'bx, "hold_x");

    // Reset mid-stream drops the in-flight result.
    drive(1'b0, 1'b1, 8'b0010_0000, "b5");
    drive(1'b1, 1'b1, 8'b1000_0000, "rst_mid");
    drive(1'b0, 1'b0, 8'h00, "after_rst");

    // Random stream with toggling valid and rare resets.
    for (int k = 0; k < 1000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = IW'(1) << $urandom_range(0, IW - 1);
        default: d = IW'($urandom);
      endcase
      drive(r, v, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
